// File: rtl/pc_flow_ctrl_pkg.sv
// rtl/pc_flow_ctrl_pkg.sv - shared bus widths, hold levels and FSM states for the PC flow controller
package pc_flow_ctrl_pkg;

   localparam int InstAddrBusW = 32;
   localparam int HoldFlagBusW = 3;

   localparam logic [HoldFlagBusW-1:0] Hold_None = 3'd0;
   localparam logic [HoldFlagBusW-1:0] Hold_Pc   = 3'd1;
   localparam logic [HoldFlagBusW-1:0] Hold_If   = 3'd2;
   localparam logic [HoldFlagBusW-1:0] Hold_Id   = 3'd3;

   localparam logic JumpEnable  = 1'b1;
   localparam logic JumpDisable = 1'b0;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_HALT_DRAIN,
      ST_HALTED,
      ST_RST_ASSERT,
      ST_RST_RELEASE
   } pc_flow_state_e;

   // Hold levels are ordered, so merging requests is a plain maximum.
   function automatic logic [HoldFlagBusW-1:0] max_hold(input logic [HoldFlagBusW-1:0] a,
                                                        input logic [HoldFlagBusW-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - merges jump/stall requests and sequences JTAG halt/reset and the bus watchdog
module pc_flow_ctrl
   import pc_flow_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = 4,
   parameter int BUS_TIMEOUT  = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ex_jump_i,
   input  logic [InstAddrBusW-1:0] ex_jump_addr_i,
   input  logic                    ex_hold_i,
   input  logic                    int_assert_i,
   input  logic [InstAddrBusW-1:0] int_addr_i,
   input  logic                    int_hold_i,
   input  logic                    rib_hold_i,
   input  logic                    jtag_halt_i,
   input  logic                    jtag_reset_i,
   output logic                    jump_flag_o,
   output logic [InstAddrBusW-1:0] jump_addr_o,
   output logic [HoldFlagBusW-1:0] hold_flag_o,
   output logic                    jtag_reset_flag_o,
   output logic                    halted_o,
   output logic                    bus_err_o
);

   localparam int RC_W = $clog2(RESET_CYCLES + 1);
   localparam int BT_W = $clog2(BUS_TIMEOUT + 1);

   pc_flow_state_e  r_state;
   logic [RC_W-1:0] r_rst_cnt;
   logic [BT_W-1:0] r_bus_cnt;
   logic [BT_W-1:0] w_bus_next;
   logic            w_jump_mask;

   assign w_jump_mask = (r_state == ST_HALTED) || (r_state == ST_RST_ASSERT) ||
                        (r_state == ST_RST_RELEASE);

   always_comb begin
      jump_flag_o = JumpDisable;
      jump_addr_o = '0;
      if (!w_jump_mask) begin
         if (int_assert_i) begin
            jump_flag_o = JumpEnable;
            jump_addr_o = int_addr_i;
         end else if (ex_jump_i) begin
            jump_flag_o = JumpEnable;
            jump_addr_o = ex_jump_addr_i;
         end
      end
   end

   always_comb begin
      hold_flag_o = Hold_None;
      if (rib_hold_i)
         hold_flag_o = max_hold(hold_flag_o, Hold_Pc);
      if (jump_flag_o || ex_hold_i || int_hold_i || (r_state != ST_RUN))
         hold_flag_o = max_hold(hold_flag_o, Hold_Id);
   end

   // A debugger reset pre-empts every state and reloads the release countdown.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state           <= ST_RUN;
         r_rst_cnt         <= '0;
         jtag_reset_flag_o <= 1'b0;
         halted_o          <= 1'b0;
      end else if (jtag_reset_i) begin
         r_state           <= ST_RST_ASSERT;
         r_rst_cnt         <= RC_W'(RESET_CYCLES);
         jtag_reset_flag_o <= 1'b1;
         halted_o          <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (jtag_halt_i)
                  r_state <= ST_HALT_DRAIN;
            end
            ST_HALT_DRAIN: begin
               if (!jtag_halt_i) begin
                  r_state <= ST_RUN;
               end else if (!ex_hold_i && !int_hold_i && !rib_hold_i) begin
                  r_state  <= ST_HALTED;
                  halted_o <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!jtag_halt_i) begin
                  r_state  <= ST_RUN;
                  halted_o <= 1'b0;
               end
            end
            ST_RST_ASSERT: begin
               if (r_rst_cnt <= RC_W'(1)) begin
                  r_state           <= ST_RST_RELEASE;
                  r_rst_cnt         <= '0;
                  jtag_reset_flag_o <= 1'b0;
               end else begin
                  r_rst_cnt <= r_rst_cnt - RC_W'(1);
               end
            end
            ST_RST_RELEASE: begin
               if (jtag_halt_i) begin
                  r_state  <= ST_HALTED;
                  halted_o <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign w_bus_next = (r_bus_cnt == BT_W'(BUS_TIMEOUT)) ? r_bus_cnt : r_bus_cnt + BT_W'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bus_cnt <= '0;
         bus_err_o <= 1'b0;
      end else if (jtag_reset_i) begin
         r_bus_cnt <= '0;
         bus_err_o <= 1'b0;
      end else if (rib_hold_i) begin
         r_bus_cnt <= w_bus_next;
         if (w_bus_next == BT_W'(BUS_TIMEOUT))
            bus_err_o <= 1'b1;
      end else begin
         r_bus_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - scoreboard bench for pc_flow_ctrl
module tb_pc_flow_ctrl;

   localparam logic [2:0] H_NONE = 3'd0;
   localparam logic [2:0] H_PC   = 3'd1;
   localparam logic [2:0] H_ID   = 3'd3;

   typedef struct packed {
      logic        jf;
      logic [31:0] ja;
      logic [2:0]  hold;
      logic        rf;
      logic        hl;
      logic        er;
   } outs_t;

   typedef struct packed {
      logic        exj;
      logic [31:0] exa;
      logic        ia;
      logic [31:0] iaddr;
      logic        exh;
      logic        ih;
      logic        rib;
      logic        halt;
      logic        jrst;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ex_jump_i = 1'b0;
   logic [31:0] ex_jump_addr_i = '0;
   logic        ex_hold_i = 1'b0;
   logic        int_assert_i = 1'b0;
   logic [31:0] int_addr_i = '0;
   logic        int_hold_i = 1'b0;
   logic        rib_hold_i = 1'b0;
   logic        jtag_halt_i = 1'b0;
   logic        jtag_reset_i = 1'b0;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic [2:0]  hold_flag_o;
   logic        jtag_reset_flag_o;
   logic        halted_o;
   logic        bus_err_o;

   int    checks = 0;
   int    failures = 0;
   outs_t exp_q[$];

   pc_flow_ctrl #(.RESET_CYCLES(4), .BUS_TIMEOUT(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i), .ex_hold_i(ex_hold_i),
      .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .int_hold_i(int_hold_i),
      .rib_hold_i(rib_hold_i), .jtag_halt_i(jtag_halt_i), .jtag_reset_i(jtag_reset_i),
      .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_flag_o(hold_flag_o),
      .jtag_reset_flag_o(jtag_reset_flag_o), .halted_o(halted_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   function automatic outs_t mk(logic jf, logic [31:0] ja, logic [2:0] hold,
                                logic rf, logic hl, logic er);
      outs_t o;
      o = '{jf: jf, ja: ja, hold: hold, rf: rf, hl: hl, er: er};
      return o;
   endfunction

   function automatic ins_t st(logic exj, logic [31:0] exa, logic ia, logic [31:0] iaddr,
                               logic exh, logic ih, logic rib, logic halt, logic jrst);
      ins_t s;
      s = '{exj: exj, exa: exa, ia: ia, iaddr: iaddr, exh: exh, ih: ih,
            rib: rib, halt: halt, jrst: jrst};
      return s;
   endfunction

   function automatic outs_t observe();
      return mk(jump_flag_o, jump_addr_o, hold_flag_o, jtag_reset_flag_o, halted_o, bus_err_o);
   endfunction

   task automatic apply(input ins_t s);
      ex_jump_i = s.exj;  ex_jump_addr_i = s.exa;
      int_assert_i = s.ia; int_addr_i = s.iaddr;
      ex_hold_i = s.exh;  int_hold_i = s.ih;
      rib_hold_i = s.rib; jtag_halt_i = s.halt; jtag_reset_i = s.jrst;
   endtask

   // Samples on the falling edge, then steps past the next rising edge.
   task automatic tick(output outs_t o);
      @(negedge clk);
      o = observe();
      @(posedge clk);
      #1;
   endtask

   localparam ins_t IDLE = '0;

   task automatic test_reset();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      apply(IDLE);
      rst_ni = 1'b0;
      #1;
      obs = observe();
      checks++;
      if (obs !== mk(0, 0, H_NONE, 0, 0, 0)) begin
         failures++;
         $display("FAIL reset_low got=%h exp=%h", obs, mk(0, 0, H_NONE, 0, 0, 0));
      end
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      stim.push_back(IDLE);                           expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 1, 0, 0));  expv.push_back(mk(0, 0, H_PC, 0, 0, 0));
      stim.push_back(IDLE);                           expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reset_idle step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_jump();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      stim.push_back(st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0));         expv.push_back(mk(1, 32'h100, H_ID, 0, 0, 0));
      stim.push_back(st(1, 32'h100, 1, 32'h8, 0, 0, 0, 0, 0));     expv.push_back(mk(1, 32'h8, H_ID, 0, 0, 0));
      stim.push_back(st(0, 32'h100, 1, 32'h20, 0, 0, 0, 0, 0));    expv.push_back(mk(1, 32'h20, H_ID, 0, 0, 0));
      stim.push_back(st(0, 32'h100, 0, 32'h20, 0, 1, 0, 0, 0));    expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 1, 0, 0));               expv.push_back(mk(0, 0, H_PC, 0, 0, 0));
      stim.push_back(IDLE);                                        expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL jump step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_halt();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      for (int k = 0; k < 3; k++) begin
         stim.push_back(st(0, 0, 0, 0, 1, 0, 0, 1, 0)); expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      end
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));       expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));       expv.push_back(mk(0, 0, H_ID, 0, 1, 0));
      stim.push_back(st(1, 32'h44, 0, 0, 0, 0, 0, 1, 0));  expv.push_back(mk(0, 0, H_ID, 0, 1, 0));
      stim.push_back(IDLE);                                expv.push_back(mk(0, 0, H_ID, 0, 1, 0));
      stim.push_back(IDLE);                                expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 1, 0, 0, 1, 0));       expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 1, 0, 0, 0, 0));       expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(IDLE);                                expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL halt step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_jtag_reset();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1));        expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(1, 32'h100, 0, 0, 0, 0, 0, 0, 0));  expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL jtag_reset step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1));        expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));        expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 1));        expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));        expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 1, 32'h80, 0, 0, 0, 1, 0));   expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));        expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));        expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));        expv.push_back(mk(0, 0, H_ID, 0, 0, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_ID, 0, 1, 0));
      stim.push_back(IDLE);                                 expv.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL back_to_back step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_bus_timeout();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      for (int k = 0; k < 10; k++) begin
         stim.push_back(st(0, 0, 0, 0, 0, 0, 1, 0, 0));
         expv.push_back(mk(0, 0, H_PC, 0, 0, (k >= 8) ? 1'b1 : 1'b0));
      end
      stim.push_back(IDLE);                            expv.push_back(mk(0, 0, H_NONE, 0, 0, 1));
      stim.push_back(st(0, 0, 0, 0, 0, 0, 1, 0, 0));   expv.push_back(mk(0, 0, H_PC, 0, 0, 1));
      stim.push_back(IDLE);                            expv.push_back(mk(0, 0, H_NONE, 0, 0, 1));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL bus_timeout step%0d got=%h exp=%h", i, obs, e);
         end
      end
   endtask

   task automatic test_async_reset();
      outs_t obs, e;
      ins_t  stim[$];
      outs_t expv[$];
      stim.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1));   expv.push_back(mk(0, 0, H_NONE, 0, 0, 1));
      stim.push_back(IDLE);                            expv.push_back(mk(0, 0, H_ID, 1, 0, 0));
      foreach (stim[i]) begin
         apply(stim[i]);
         exp_q.push_back(expv[i]);
         tick(obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL async_pre step%0d got=%h exp=%h", i, obs, e);
         end
      end
      rst_ni = 1'b0;
      exp_q.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      #1;
      obs = observe();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", obs, e);
      end
      #1;
      rst_ni = 1'b1;
      apply(IDLE);
      exp_q.push_back(mk(0, 0, H_NONE, 0, 0, 0));
      tick(obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL async_post got=%h exp=%h", obs, e);
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_halt();
      test_jtag_reset();
      test_back_to_back();
      test_bus_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
